// File: rtl/mem_rd_pkg.sv
// mem_rd_pkg: FSM state, alignment marker bundle and geometry helpers
// shared by the frame reader/writer blocks.
package mem_rd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN
  } state_e;

  typedef struct packed {
    logic vld;
    logic sof;
    logic eol;
  } mark_t;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  function automatic int bank_base(input int bank, input int frame_pixels);
    return bank * frame_pixels;
  endfunction

endpackage

// File: rtl/mem_rd_frame_if.sv
// mem_rd_frame_if: BRAM read port plus FIFO write port of the frame reader.
// master = reader side, slave = BRAM/FIFO side.
interface mem_rd_frame_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 20
);
  logic              o_rd_en;
  logic [ADDR_W-1:0] o_raddr;
  logic [DATA_W-1:0] i_rdata;
  logic              o_wr;
  logic [DATA_W-1:0] o_wdata;
  logic              o_sof;
  logic              o_eol;
  logic              i_almostfull;

  modport master (
    output o_rd_en, o_raddr, o_wr, o_wdata, o_sof, o_eol,
    input  i_rdata, i_almostfull
  );

  modport slave (
    input  o_rd_en, o_raddr, o_wr, o_wdata, o_sof, o_eol,
    output i_rdata, i_almostfull
  );
endinterface

// File: rtl/sync_edge.sv
// sync_edge: two-flop synchroniser followed by a rising-edge detector.
// Shared by the frame reader and writer request paths.
module sync_edge (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_async,
  output logic o_rise
);
  logic [2:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[1:0], i_async};

  always_ff @(posedge i_clk) begin
    if (!i_rstn) sync_q <= '0;
    else         sync_q <= sync_d;
  end

  assign o_rise = sync_q[1] && !sync_q[2];
endmodule

// File: rtl/mem_rd_frame.sv
// mem_rd_frame: streams one frame from a banked BRAM into a FIFO.
// Define MEM_RD_FRAME_TPG_EN to add the i_tpg test-pattern source.
module mem_rd_frame
  import mem_rd_pkg::*;
#(
  parameter int DATA_W     = 12,
  parameter int LINE_W     = 640,
  parameter int LINES      = 480,
  parameter int NUM_BANKS  = 2,
  parameter int RD_LATENCY = 2
) (
  input  logic                              i_clk,
  input  logic                              i_rstn,
  input  logic                              i_req,
  input  logic [clog2_min1(NUM_BANKS)-1:0]  i_bank,
`ifdef MEM_RD_FRAME_TPG_EN
  input  logic                              i_tpg,
`endif
  mem_rd_frame_if.master                    bus,
  output logic                              o_busy,
  output logic                              o_done
);
  localparam int FRAME_PIXELS = LINE_W * LINES;
  localparam int ADDR_W = clog2_min1(FRAME_PIXELS * NUM_BANKS);
  localparam int PIX_W  = clog2_min1(FRAME_PIXELS);
  localparam int COL_W  = clog2_min1(LINE_W);
  localparam int L      = RD_LATENCY;

  state_e            state_q, state_d;
  logic              start, issue, last_px, drained;
  logic [ADDR_W-1:0] base_q, base_d, raddr_q, raddr_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              rden_q, rden_d;
  mark_t             rd_q, rd_d, out_q, out_d;
  mark_t [L-1:0]     pipe_q, pipe_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
`ifdef MEM_RD_FRAME_TPG_EN
  localparam int LN_W = clog2_min1(LINES);
  logic                   tpg_q, tpg_d;
  logic [LN_W-1:0]        ln_q, ln_d;
  logic [L:0][DATA_W-1:0] tdat_q, tdat_d;
`endif

  sync_edge u_sync (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_async (i_req),
    .o_rise  (start)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      base_q  <= '0;
      raddr_q <= '0;
      pix_q   <= '0;
      col_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rden_q  <= 1'b0;
      rd_q    <= '0;
      pipe_q  <= '0;
      out_q   <= '0;
      wdata_q <= '0;
`ifdef MEM_RD_FRAME_TPG_EN
      tpg_q   <= 1'b0;
      ln_q    <= '0;
      tdat_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      raddr_q <= raddr_d;
      pix_q   <= pix_d;
      col_q   <= col_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rden_q  <= rden_d;
      rd_q    <= rd_d;
      pipe_q  <= pipe_d;
      out_q   <= out_d;
      wdata_q <= wdata_d;
`ifdef MEM_RD_FRAME_TPG_EN
      tpg_q   <= tpg_d;
      ln_q    <= ln_d;
      tdat_q  <= tdat_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)   state_d = ACTIVE;
      ACTIVE:  if (last_px) state_d = DRAIN;
      DRAIN:   if (drained) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    issue   = (state_q == ACTIVE) && !bus.i_almostfull;
    last_px = issue && (pix_q == PIX_W'(FRAME_PIXELS - 1));
    drained = !rd_q.vld;
    for (int i = 0; i < L; i++) drained = drained && !pipe_q[i].vld;

    base_d = base_q;
    pix_d  = pix_q;
    col_d  = col_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (state_q == IDLE && start) begin
      base_d = ADDR_W'(bank_base(int'(i_bank), FRAME_PIXELS));
      pix_d  = '0;
      col_d  = '0;
      busy_d = 1'b1;
    end
    if (issue) begin
      pix_d = pix_q + PIX_W'(1);
      col_d = (col_q == COL_W'(LINE_W - 1)) ? '0 : col_q + COL_W'(1);
    end
    if (state_q == DRAIN && drained) begin
      done_d = 1'b1;
      busy_d = 1'b0;
    end

    // Markers ride with each read so they line up with the returned data.
    rd_d.vld = issue;
    rd_d.sof = issue && (pix_q == '0);
    rd_d.eol = issue && (col_q == COL_W'(LINE_W - 1));
    raddr_d  = issue ? base_q + ADDR_W'(pix_q) : raddr_q;

    pipe_d[0] = rd_q;
    for (int i = 1; i < L; i++) pipe_d[i] = pipe_q[i-1];
    out_d   = pipe_q[L-1];
    wdata_d = pipe_q[L-1].vld ? bus.i_rdata : wdata_q;

`ifdef MEM_RD_FRAME_TPG_EN
    tpg_d = (state_q == IDLE && start) ? i_tpg : tpg_q;
    ln_d  = ln_q;
    if (state_q == IDLE && start) ln_d = '0;
    else if (issue && col_q == COL_W'(LINE_W - 1)) ln_d = ln_q + LN_W'(1);
    tdat_d[0] = DATA_W'({4'(ln_q), col_q});
    for (int i = 1; i <= L; i++) tdat_d[i] = tdat_q[i-1];
    rden_d = issue && !tpg_q;
    if (pipe_q[L-1].vld && tpg_q) wdata_d = tdat_q[L];
`else
    rden_d = issue;
`endif
  end

  assign bus.o_rd_en = rden_q;
  assign bus.o_raddr = raddr_q;
  assign bus.o_wr    = out_q.vld;
  assign bus.o_wdata = wdata_q;
  assign bus.o_sof   = out_q.sof;
  assign bus.o_eol   = out_q.eol;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
endmodule

// File: tb/tb_mem_rd_frame.sv
// tb_mem_rd_frame: bench for mem_rd_frame on a 4x4 frame, 2 banks, latency 2.
// Define MEM_RD_FRAME_TPG_EN to also cover the test-pattern source.
`timescale 1ns/1ps
module tb_mem_rd_frame;
  import mem_rd_pkg::*;

  localparam int DATA_W     = 12;
  localparam int LINE_W     = 4;
  localparam int LINES      = 4;
  localparam int NUM_BANKS  = 2;
  localparam int RD_LATENCY = 2;
  localparam int FP         = LINE_W * LINES;
  localparam int ADDR_W     = clog2_min1(FP * NUM_BANKS);
  localparam int COL_W      = clog2_min1(LINE_W);
`ifdef MEM_RD_FRAME_TPG_EN
  localparam bit TPG_BUILD = 1'b1;
`else
  localparam bit TPG_BUILD = 1'b0;
`endif

  typedef struct {
    int bank;
    int stall_at;
    int stall_len;
    bit rand_af;
    bit dup;
    bit flip;
    bit tpg;
    int exp_base;
    int exp_writes;
    int exp_done;
  } vec_t;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       req  = 1'b0;
  logic       tpg  = 1'b0;
  logic [0:0] bank = 1'b0;
  logic       busy, done;

  mem_rd_frame_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mem_rd_frame #(
    .DATA_W(DATA_W), .LINE_W(LINE_W), .LINES(LINES),
    .NUM_BANKS(NUM_BANKS), .RD_LATENCY(RD_LATENCY)
  ) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .i_req  (req),
    .i_bank (bank),
`ifdef MEM_RD_FRAME_TPG_EN
    .i_tpg  (tpg),
`endif
    .bus    (bus),
    .o_busy (busy),
    .o_done (done)
  );

  always #5 clk = ~clk;

  // BRAM: returns the address as data RD_LATENCY cycles after a read.
  logic [RD_LATENCY-1:0] bv = '0;
  logic [ADDR_W-1:0]     ba [RD_LATENCY];
  always @(posedge clk) begin
    bv[0] <= bus.o_rd_en;
    ba[0] <= bus.o_raddr;
    for (int i = 1; i < RD_LATENCY; i++) begin
      bv[i] <= bv[i-1];
      ba[i] <= ba[i-1];
    end
  end
  assign bus.i_rdata = bv[RD_LATENCY-1] ? DATA_W'(ba[RD_LATENCY-1]) : '1;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  int   cyc = 0;
  logic af_prev = 1'b0;
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    af_prev <= bus.i_almostfull;
  end

  int                rd_cyc[$], wr_cyc[$], done_cyc[$], rise_cyc[$], req_cyc[$];
  logic [ADDR_W-1:0] rd_addr[$];
  logic [DATA_W+1:0] wr_rec[$];
  logic              busy_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.o_rd_en) begin
      rd_cyc.push_back(cyc);
      rd_addr.push_back(bus.o_raddr);
      chk("no_rd_in_stall", af_prev, 0);
    end
    if (bus.o_wr) begin
      wr_cyc.push_back(cyc);
      wr_rec.push_back({bus.o_sof, bus.o_eol, bus.o_wdata});
    end
    if (done) done_cyc.push_back(cyc);
    if (busy && !busy_prev) rise_cyc.push_back(cyc);
    busy_prev = busy;
  end

  task automatic clear_q();
    rd_cyc.delete(); wr_cyc.delete(); done_cyc.delete();
    rise_cyc.delete(); req_cyc.delete(); rd_addr.delete(); wr_rec.delete();
  endtask

  // Reference: write j of a frame is pixel j, line j/LINE_W, col j%LINE_W.
  function automatic int exp_data(input int base, input int j, input bit t);
    if (t) return ((j / LINE_W) % 16) * (1 << COL_W) + (j % LINE_W);
    return base + j;
  endfunction

  task automatic check_frames(input int base, input int nwr, input int ndone,
                              input bit t, input bit timing);
    chk("wr_count", wr_rec.size(), nwr);
    chk("rd_count", rd_addr.size(), t ? 0 : nwr);
    chk("done_count", done_cyc.size(), ndone);
    chk("busy_rises", rise_cyc.size(), ndone);
    for (int i = 0; i < wr_rec.size() && i < nwr; i++) begin
      int j = i % FP;
      int e = ((j == 0) ? (1 << (DATA_W + 1)) : 0)
            | ((j % LINE_W == LINE_W - 1) ? (1 << DATA_W) : 0)
            | exp_data(base, j, t);
      chk($sformatf("write%0d_sof_eol_data", i), int'(wr_rec[i]), e);
      if (!t && i < rd_addr.size()) begin
        chk($sformatf("raddr%0d", i), int'(rd_addr[i]), base + j);
        chk($sformatf("rd_to_wr%0d", i), wr_cyc[i] - rd_cyc[i], RD_LATENCY + 1);
      end
      if (timing && rise_cyc.size() > 0)
        chk($sformatf("wr_time%0d", i), wr_cyc[i] - rise_cyc[0], RD_LATENCY + 2 + i);
    end
    for (int f = 0; f < done_cyc.size() && f * FP + FP - 1 < wr_cyc.size(); f++)
      chk("done_after_last_wr", done_cyc[f] - wr_cyc[f * FP + FP - 1], 1);
    for (int f = 0; f < rise_cyc.size() && f < req_cyc.size(); f++)
      chk("start_latency", rise_cyc[f] - req_cyc[f], 3);
  endtask

  task automatic run_frame(input vec_t v);
    int t = 0;
    bit use_tpg = v.tpg && TPG_BUILD;
    clear_q();
    @(negedge clk);
    bank = 1'(v.bank);
    tpg  = v.tpg;
    req  = 1'b1;
    req_cyc.push_back(cyc);
    while (done_cyc.size() == 0 && t < 500) begin
      @(negedge clk);
      t++;
      if (v.dup && t == 6) req = 1'b0;
      if (v.dup && t == 10) req = 1'b1;
      if (v.flip && t == 8) bank = ~bank;
      if (v.rand_af) bus.i_almostfull = ($urandom_range(0, 2) == 0);
      else bus.i_almostfull = (t >= v.stall_at && t < v.stall_at + v.stall_len);
    end
    chk("frame_done_in_time", done_cyc.size() > 0, 1);
    bus.i_almostfull = 1'b0;
    req = 1'b0;
    repeat (10) @(negedge clk);
    check_frames(v.exp_base, v.exp_writes, v.exp_done, use_tpg,
                 v.stall_len == 0 && !v.rand_af);
  endtask

  vec_t tbl[6];

  initial begin
    int t;
    vec_t rv;
    bus.i_almostfull = 1'b0;

    tbl[0] = '{bank:1, stall_at:0, stall_len:0, rand_af:0, dup:0, flip:0, tpg:1,
               exp_base:16, exp_writes:16, exp_done:1};
    tbl[1] = '{bank:1, stall_at:8, stall_len:5, rand_af:0, dup:0, flip:0, tpg:0,
               exp_base:16, exp_writes:16, exp_done:1};
    tbl[2] = '{bank:1, stall_at:0, stall_len:0, rand_af:0, dup:1, flip:1, tpg:1,
               exp_base:16, exp_writes:16, exp_done:1};
    tbl[3] = '{bank:0, stall_at:0, stall_len:0, rand_af:0, dup:0, flip:0, tpg:0,
               exp_base:0, exp_writes:16, exp_done:1};
    tbl[4] = '{bank:0, stall_at:5, stall_len:3, rand_af:0, dup:0, flip:0, tpg:0,
               exp_base:0, exp_writes:16, exp_done:1};
    tbl[5] = '{bank:1, stall_at:0, stall_len:0, rand_af:1, dup:0, flip:0, tpg:0,
               exp_base:16, exp_writes:16, exp_done:1};

    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({bus.o_rd_en, bus.o_raddr, bus.o_wr, bus.o_wdata,
                               bus.o_sof, bus.o_eol, busy, done}), 0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    for (int k = 0; k < 6; k++) run_frame(tbl[k]);

`ifdef MEM_RD_FRAME_TPG_EN
    run_frame(tbl[0]);
    if (wr_rec.size() > 11) chk("tpg_line2_col3", int'(wr_rec[11][DATA_W-1:0]), 11);
`endif

    for (int k = 0; k < 4; k++) begin
      rv = tbl[5];
      rv.bank = int'($urandom_range(0, 1));
      rv.tpg = 1'($urandom_range(0, 1));
      rv.exp_base = rv.bank * FP;
      run_frame(rv);
    end

    // Reset in the middle of a frame.
    clear_q();
    @(negedge clk);
    bank = 1'b1; tpg = 1'b0; req = 1'b1;
    t = 0;
    while (wr_rec.size() < 8 && t < 500) begin
      @(negedge clk);
      t++;
    end
    rstn = 1'b0;
    req  = 1'b0;
    @(negedge clk);
    chk("midframe_reset_outputs", int'({bus.o_rd_en, bus.o_raddr, bus.o_wr, bus.o_wdata,
                                        bus.o_sof, bus.o_eol, busy, done}), 0);
    clear_q();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_wr_after_reset", wr_rec.size(), 0);
    chk("no_done_after_reset", done_cyc.size(), 0);
    run_frame(tbl[3]);

    // Back-to-back: second edge lands exactly on the cycle after o_done.
    clear_q();
    @(negedge clk);
    bank = 1'b1; tpg = 1'b0; req = 1'b1;
    req_cyc.push_back(cyc);
    t = 0;
    while (done_cyc.size() < 2 && t < 500) begin
      @(negedge clk);
      t++;
      if (t == 6) req = 1'b0;
      if (rise_cyc.size() == 1 && cyc == rise_cyc[0] + 18) begin
        req = 1'b1;
        req_cyc.push_back(cyc);
      end
    end
    req = 1'b0;
    repeat (10) @(negedge clk);
    check_frames(16, 2 * FP, 2, 1'b0, 1'b0);
    if (rise_cyc.size() > 1 && done_cyc.size() > 0)
      chk("b2b_start_after_done", rise_cyc[1] - done_cyc[0], 1);
    else
      chk("b2b_second_frame_seen", rise_cyc.size(), 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
